skolem_bvslt_bvmul_seq: RTL

- Sequential, width-parametrised Skolem witness generator for the constraint bvslt(bvmul(A, Y), B).
- Given signed W-bit operands A and B, it searches candidates Y = 0, 1, 2, ... in order and returns the first Y for which (A*Y mod 2^W) < B under signed comparison.
- If no such Y exists, it reports unsat.
- It is the next generation of the team's fixed-width combinational Skolem netlists. It sits behind the constraint front-end on a valid/ready stream.

---
 rtl/skolem_bvslt_bvmul_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/skolem_bvslt_bvmul_seq.sv
// Sequential Skolem witness search for bvslt(bvmul(A, Y), B): scans Y = 0, 1, ... and reports the first hit or unsat.
// Optional macro SKOLEM_EARLY_UNSAT_EN resolves provably unsatisfiable requests without scanning.
module skolem_bvslt_bvmul_seq #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y_out,
    output logic         found,
    output logic [W:0]   tries
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] c_q, c_d;
    logic [W-1:0] y_q, y_d;
    logic         found_q, found_d;
    logic [W:0]   tries_q, tries_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;

    logic [W-1:0] prod;
    logic         hit;
    logic         last;

    assign prod = a_q * c_q;
    assign hit  = $signed(prod) < $signed(b_q);
    assign last = (c_q == '1);

`ifdef SKOLEM_EARLY_UNSAT_EN
    logic early_q, early_d;
    logic early_unsat;

    assign early_unsat = (b_in == {1'b1, {(W-1){1'b0}}})
                      || ((a_in == '0) && ($signed(b_in) <= $signed({W{1'b0}})));
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        y_d         = y_q;
        found_d     = found_q;
        tries_d     = tries_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef SKOLEM_EARLY_UNSAT_EN
        early_d     = early_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a_in;
                    b_d        = b_in;
                    c_d        = '0;
                    tries_d    = '0;
                    in_ready_d = 1'b0;
                    state_d    = SEARCH;
`ifdef SKOLEM_EARLY_UNSAT_EN
                    early_d    = early_unsat;
`endif
                end
            end

            SEARCH: begin
`ifdef SKOLEM_EARLY_UNSAT_EN
                // Early-unsat requests spend one SEARCH cycle so out_valid still rises one edge after accept.
                if (early_q) begin
                    y_d         = '0;
                    found_d     = 1'b0;
                    tries_d     = '0;
                    out_valid_d = 1'b1;
                    early_d     = 1'b0;
                    state_d     = DONE;
                end else
`endif
                if (hit) begin
                    y_d         = c_q;
                    found_d     = 1'b1;
                    tries_d     = {1'b0, c_q} + (W+1)'(1);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (last) begin
                    y_d         = '0;
                    found_d     = 1'b0;
                    tries_d     = {1'b1, {W{1'b0}}};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    c_d = c_q + W'(1);
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            y_q         <= '0;
            found_q     <= 1'b0;
            tries_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SKOLEM_EARLY_UNSAT_EN
            early_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            y_q         <= y_d;
            found_q     <= found_d;
            tries_q     <= tries_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SKOLEM_EARLY_UNSAT_EN
            early_q     <= early_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y_out     = y_q;
    assign found     = found_q;
    assign tries     = tries_q;

endmodule
